// File: rtl/iob_eth_mdio_ctrl_if.sv
// Command/response port of the Ethernet PHY management controller.
// master = command issuer, slave = iob_eth_mdio_ctrl.
interface iob_eth_mdio_ctrl_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_rd;
   logic [4:0]  cmd_phyad;
   logic [4:0]  cmd_regad;
   logic [15:0] cmd_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        busy;

   modport master (
      output cmd_valid, cmd_rd, cmd_phyad, cmd_regad, cmd_wdata,
      input  cmd_ready, rsp_valid, rsp_rdata, busy
   );

   modport slave (
      input  cmd_valid, cmd_rd, cmd_phyad, cmd_regad, cmd_wdata,
      output cmd_ready, rsp_valid, rsp_rdata, busy
   );
endinterface

// File: rtl/iob_eth_mdio_ctrl.sv
// Ethernet PHY management: sequences ETH_PHY_RESETN after reset, then runs one
// Clause-22 MDIO read/write frame per accepted command.
module iob_eth_mdio_ctrl #(
   parameter int CLK_DIV      = 25,
   parameter int PHY_RST_CYC  = 1000,
   parameter int PHY_WAIT_CYC = 5000
) (
   input  logic                 clk,
   input  logic                 rst,
   iob_eth_mdio_ctrl_if.slave   bus,
   output logic                 ETH_PHY_RESETN,
   output logic                 MDC,
   output logic                 MDIO_O,
   output logic                 MDIO_OE,
   input  logic                 MDIO_I
);

   localparam int CNT_MAX = (PHY_RST_CYC > PHY_WAIT_CYC) ? PHY_RST_CYC : PHY_WAIT_CYC;
   localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
   localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PHY_RST_CYC - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(PHY_WAIT_CYC - 1);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);

   localparam logic [2:0] S_PHY_RST  = 3'd0;
   localparam logic [2:0] S_PHY_WAIT = 3'd1;
   localparam logic [2:0] S_IDLE     = 3'd2;
   localparam logic [2:0] S_SHIFT    = 3'd3;
   localparam logic [2:0] S_DONE     = 3'd4;

   if (CLK_DIV < 2) begin : g_div_chk
      $error("iob_eth_mdio_ctrl: CLK_DIV must be >= 2");
   end

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [5:0]       bit_q, bit_d;
   logic [63:0]      frame_q, frame_d;
   logic             rd_q, rd_d;
   logic             mdc_q, mdc_d;
   logic             mdo_q, mdo_d;
   logic             oe_q, oe_d;
   logic             rstn_q, rstn_d;
   logic [15:0]      rdata_q, rdata_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      bit_d   = bit_q;
      frame_d = frame_q;
      rd_d    = rd_q;
      mdc_d   = mdc_q;
      mdo_d   = mdo_q;
      oe_d    = oe_q;
      rstn_d  = rstn_q;
      rdata_d = rdata_q;
      case (state_q)
         S_PHY_RST: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == RST_LAST) begin
               cnt_d   = '0;
               rstn_d  = 1'b1;
               state_d = S_PHY_WAIT;
            end
         end
         S_PHY_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == WAIT_LAST) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         S_IDLE: begin
            if (bus.cmd_valid) begin
               // Read: TA/data slots are placeholders, the pad is released there.
               frame_d = {32'hFFFF_FFFF, 2'b01,
                          bus.cmd_rd ? 2'b10 : 2'b01,
                          bus.cmd_phyad, bus.cmd_regad,
                          bus.cmd_rd ? 2'b11 : 2'b10,
                          bus.cmd_rd ? 16'hFFFF : bus.cmd_wdata};
               rd_d    = bus.cmd_rd;
               mdo_d   = 1'b1;
               oe_d    = 1'b1;
               mdc_d   = 1'b0;
               div_d   = '0;
               bit_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            div_d = div_q + 1'b1;
            if (div_q == DIV_LAST) begin
               div_d = '0;
               mdc_d = ~mdc_q;
               if (!mdc_q) begin
                  // Rising MDC: advance the frame, capturing MDIO_I for data bits of a read.
                  frame_d = {frame_q[62:0], (rd_q && bit_q >= 6'd48) ? MDIO_I : 1'b0};
               end else if (bit_q == 6'd63) begin
                  mdo_d   = 1'b1;
                  oe_d    = 1'b0;
                  if (rd_q) rdata_d = frame_q[15:0];
                  state_d = S_DONE;
               end else begin
                  bit_d = bit_q + 1'b1;
                  mdo_d = frame_q[63];
                  oe_d  = ~(rd_q && bit_q >= 6'd45);
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_PHY_RST;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_PHY_RST;
         cnt_q   <= '0;
         div_q   <= '0;
         bit_q   <= '0;
         frame_q <= '0;
         rd_q    <= 1'b0;
         mdc_q   <= 1'b0;
         mdo_q   <= 1'b1;
         oe_q    <= 1'b0;
         rstn_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         frame_q <= frame_d;
         rd_q    <= rd_d;
         mdc_q   <= mdc_d;
         mdo_q   <= mdo_d;
         oe_q    <= oe_d;
         rstn_q  <= rstn_d;
         rdata_q <= rdata_d;
      end
   end

   assign bus.cmd_ready  = (state_q == S_IDLE);
   assign bus.rsp_valid  = (state_q == S_DONE);
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.rsp_rdata  = rdata_q;
   assign ETH_PHY_RESETN = rstn_q;
   assign MDC            = mdc_q;
   assign MDIO_O         = mdo_q;
   assign MDIO_OE        = oe_q;

endmodule

// File: tb/tb_iob_eth_mdio_ctrl.sv
// Bench for iob_eth_mdio_ctrl: frame-level model of Clause-22 MDIO with a PHY
// responder, table vectors, random commands and reset/back-to-back corner cases.
module tb_iob_eth_mdio_ctrl;
  localparam int CLK_DIV   = 2;
  localparam int RST_CYC   = 10;
  localparam int WAIT_CYC  = 20;
  localparam int FRAME_CYC = 128 * CLK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic eth_rstn, mdc, mdio_o, mdio_oe;
  logic mdio_i = 1'b1;

  iob_eth_mdio_ctrl_if bus ();

  iob_eth_mdio_ctrl #(
    .CLK_DIV(CLK_DIV), .PHY_RST_CYC(RST_CYC), .PHY_WAIT_CYC(WAIT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ETH_PHY_RESETN(eth_rstn), .MDC(mdc), .MDIO_O(mdio_o),
    .MDIO_OE(mdio_oe), .MDIO_I(mdio_i)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;
  logic [15:0] m_rdata = 16'h0;

  typedef struct {
    bit          rd;
    logic [4:0]  pa;
    logic [4:0]  ra;
    logic [15:0] wd;
    logic [15:0] pd;
    logic [15:0] exp_rdata;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Expected frame from the protocol fields, MSB = first bit on the wire.
  function automatic logic [63:0] exp_frame(input bit rd, input logic [4:0] pa,
                                            input logic [4:0] ra, input logic [15:0] wd);
    logic [63:0] f;
    f = '1;
    f[31:30] = 2'b01;
    f[29:28] = rd ? 2'b10 : 2'b01;
    f[27:23] = pa;
    f[22:18] = ra;
    f[17:16] = 2'b10;
    f[15:0]  = wd;
    return f;
  endfunction

  task automatic reset_seq();
    int rstn_k, rdy_k;
    bit noisy;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    mdio_i = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs", 64'({eth_rstn, mdc, mdio_o, mdio_oe, bus.cmd_ready, bus.rsp_valid, bus.busy}),
          64'b0010001);
    check("reset_rdata", 64'(bus.rsp_rdata), 64'h0);
    rst = 1'b0;
    m_rdata = 16'h0;
    rstn_k = 0; rdy_k = 0; noisy = 1'b0;
    for (int k = 1; k <= RST_CYC + WAIT_CYC + 10 && rdy_k == 0; k++) begin
      @(negedge clk);
      if (eth_rstn && rstn_k == 0) rstn_k = k;
      if (bus.cmd_ready) rdy_k = k;
      noisy |= bus.rsp_valid | mdc | mdio_oe;
    end
    check("phy_resetn_rise", 64'(rstn_k), 64'(RST_CYC));
    check("first_ready", 64'(rdy_k), 64'(RST_CYC + WAIT_CYC));
    check("idle_busy", 64'(bus.busy), 64'h0);
    check("reset_quiet", 64'(noisy), 64'h0);
  endtask

  // Issues one command, plays the PHY, and checks the captured frame.
  task automatic run_cmd(input bit rd, input logic [4:0] pa, input logic [4:0] ra,
                         input logic [15:0] wd, input logic [15:0] pd,
                         input bit keep, input bit b2b, input int abort_bit);
    logic [63:0] got_o, got_oe, ef, mask, eoe;
    logic [15:0] rd_at;
    int rises, first_k, rsp_k, wt;
    bit mdc_prev, rdy_seen;
    bus.cmd_rd = rd; bus.cmd_phyad = pa; bus.cmd_regad = ra; bus.cmd_wdata = wd;
    bus.cmd_valid = 1'b1;
    wt = 0;
    while (!bus.cmd_ready && wt < 50) begin
      @(negedge clk);
      wt++;
    end
    check("accept_wait", 64'(wt), b2b ? 64'd1 : 64'd0);
    if (!bus.cmd_ready) begin
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    got_o = '0; got_oe = '0; rd_at = '0;
    rises = 0; first_k = 0; rsp_k = 0; mdc_prev = 1'b0; rdy_seen = 1'b0;
    for (int k = 1; k <= FRAME_CYC + 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        // Scramble inputs: the latched command must be unaffected.
        bus.cmd_phyad = 5'($urandom); bus.cmd_regad = 5'($urandom);
        bus.cmd_wdata = 16'($urandom); bus.cmd_rd = 1'($urandom);
        if (!keep) bus.cmd_valid = 1'b0;
      end
      if (mdc && !mdc_prev) begin
        if (rises < 64) begin
          got_o[63-rises]  = mdio_o;
          got_oe[63-rises] = mdio_oe;
        end
        if (rises == 0) first_k = k;
        rises++;
      end
      mdc_prev = mdc;
      rdy_seen |= bus.cmd_ready;
      if (abort_bit >= 0 && rises == abort_bit + 1) begin
        rst = 1'b1;
        #1;
        check("abort_outs", 64'({mdc, mdio_oe, eth_rstn, bus.rsp_valid, bus.cmd_ready}), 64'h0);
        bus.cmd_valid = 1'b0;
        mdio_i = 1'b1;
        return;
      end
      if (bus.rsp_valid) begin
        rsp_k = k;
        rd_at = bus.rsp_rdata;
        break;
      end
      mdio_i = (rises >= 48 && rises < 64) ? pd[63-rises] : 1'b1;
    end
    mdio_i = 1'b1;
    ef   = exp_frame(rd, pa, ra, wd);
    eoe  = rd ? {{46{1'b1}}, {18{1'b0}}} : {64{1'b1}};
    mask = eoe;
    check("frame_bits", got_o & mask, ef & mask);
    check("frame_oe", got_oe, eoe);
    check("mdc_rises", 64'(rises), 64'd64);
    check("first_rise", 64'(first_k), 64'(CLK_DIV + 1));
    check("rsp_latency", 64'(rsp_k), 64'(FRAME_CYC + 1));
    check("no_accept_in_frame", 64'(rdy_seen), 64'h0);
    if (rd) m_rdata = pd;
    check("rsp_rdata", 64'(rd_at), 64'(m_rdata));
  endtask

  task automatic post_idle();
    @(negedge clk);
    check("idle_after", 64'({bus.busy, bus.cmd_ready, bus.rsp_valid, mdc, mdio_oe}), 64'b01000);
    check("rdata_hold", 64'(bus.rsp_rdata), 64'(m_rdata));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[5];
    bus.cmd_valid = 1'b0; bus.cmd_rd = 1'b0;
    bus.cmd_phyad = '0; bus.cmd_regad = '0; bus.cmd_wdata = '0;

    tbl[0] = '{rd: 1'b0, pa: 5'd1, ra: 5'd0, wd: 16'h1140, pd: 16'h0000, exp_rdata: 16'h0000};
    tbl[1] = '{rd: 1'b1, pa: 5'd3, ra: 5'd2, wd: 16'h0000, pd: 16'h0141, exp_rdata: 16'h0141};
    tbl[2] = '{rd: 1'b1, pa: 5'd7, ra: 5'd1, wd: 16'h0000, pd: 16'hFFFF, exp_rdata: 16'hFFFF};
    tbl[3] = '{rd: 1'b0, pa: 5'd7, ra: 5'd4, wd: 16'hA5C3, pd: 16'h1234, exp_rdata: 16'hFFFF};
    tbl[4] = '{rd: 1'b1, pa: 5'd7, ra: 5'd1, wd: 16'hFFFF, pd: 16'h0000, exp_rdata: 16'h0000};

    reset_seq();

    for (int i = 0; i < 5; i++) begin
      run_cmd(tbl[i].rd, tbl[i].pa, tbl[i].ra, tbl[i].wd, tbl[i].pd, 1'b0, 1'b0, -1);
      post_idle();
      check("tbl_rdata", 64'(bus.rsp_rdata), 64'(tbl[i].exp_rdata));
    end

    // cmd_valid held through a write; the next command goes right after rsp_valid.
    run_cmd(1'b0, 5'd2, 5'd9, 16'h0F0F, 16'h0, 1'b1, 1'b0, -1);
    run_cmd(1'b1, 5'd2, 5'd9, 16'h0, 16'h3C5A, 1'b0, 1'b1, -1);
    post_idle();

    for (int i = 0; i < 6; i++) begin
      run_cmd(1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 16'($urandom),
              1'b0, 1'b0, -1);
      post_idle();
    end

    // Make rsp_rdata nonzero, then abort a read mid-frame with rst.
    run_cmd(1'b1, 5'd5, 5'd3, 16'h0, 16'hBEEF, 1'b0, 1'b0, -1);
    post_idle();
    run_cmd(1'b1, 5'd5, 5'd3, 16'h0, 16'h1357, 1'b0, 1'b0, 40);
    reset_seq();
    run_cmd(1'b0, 5'd1, 5'd0, 16'h8000, 16'h0, 1'b0, 1'b0, -1);
    post_idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
